// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Default sizing targets the DE2 board at 50 MHz.
package switch_debouncer_pkg;

  localparam int SW_WIDTH         = 18;
  localparam int DEB_TICK_DIV     = 50000;
  localparam int DEB_STABLE_TICKS = 16;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } deb_state_e;

  // Counter width for a range of n values, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter
// paced by the shared tick, and a one-cycle change strobe.
module switch_debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic changed
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic          clean_q;
  logic          clean_d;
  logic          chg_q;
  logic          chg_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  deb_state_e    state;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accepted level, qualification count and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_q <= 1'b0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  // IDLE clears the count every cycle so any glitch restarts
  // qualification; PENDING advances only on ticks.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    chg_d   = 1'b0;
    state   = (sync2 == clean_q) ? ST_IDLE : ST_PENDING;
    unique case (state)
      ST_IDLE: begin
        cnt_d = '0;
      end
      ST_PENDING: begin
        cnt_d = cnt_q;
        if (tick) begin
          if (cnt_q == LAST) begin
            clean_d = sync2;
            cnt_d   = '0;
            chg_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign clean   = clean_q;
  assign changed = chg_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw slide switches ahead of the switch PIO.
// Shared prescaler plus one debounce slice per switch bit.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = DEB_TICK_DIV,
  parameter int STABLE_TICKS = DEB_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             tick
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = (pre == PRE_LAST);

  // Free-running prescaler, wraps on the tick cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .tick   (tick),
      .clean  (sw_clean[i]),
      .changed(sw_changed[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4,
// STABLE_TICKS=3: accept latency 11..14 cycles from sw_raw.
module tb_switch_debouncer;

  localparam int W = 18;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_changed;
  logic         tick;

  int errors;
  int checks;

  switch_debouncer #(
    .WIDTH       (W),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_changed(sw_changed),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until any strobe appears, bounded by limit.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (sw_changed == '0 && n < limit);
  endtask

  // Runs n cycles, counting cycles with any strobe.
  task automatic quiet(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      cyc(1);
      if (sw_changed != '0) hits++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  int n;
  int h;
  int h2;
  int acc;

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    sw_raw  = 18'h3FFFF;

    // 1: reset values, then switches held through reset qualify
    cyc(3);
    check("rst_clean", 32'(sw_clean), 32'h0);
    check("rst_changed", 32'(sw_changed), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset_n = 1'b1;
    wait_pulse(30, n);
    check("rst_lat", 32'(n >= 11 && n <= 14), 32'h1);
    check("rst_pulse", 32'(sw_changed), 32'h3FFFF);
    check("rst_pclean", 32'(sw_clean), 32'h3FFFF);
    cyc(1);
    check("rst_once", 32'(sw_changed), 32'h0);
    check("rst_final", 32'(sw_clean), 32'h3FFFF);

    // prescaler period
    sw_raw = '0;
    do_reset();
    n = 0;
    while (!tick && n < 10) begin
      cyc(1);
      n++;
    end
    check("tick_seen", 32'(tick), 32'h1);
    cyc(1);
    n = 1;
    while (!tick && n < 10) begin
      cyc(1);
      n++;
    end
    check("tick_period", 32'(n), 32'd4);

    // 2: clean step on bit 0
    cyc(1);
    sw_raw[0] = 1'b1;
    wait_pulse(30, n);
    check("step_lat", 32'(n >= 11 && n <= 14), 32'h1);
    check("step_pulse", 32'(sw_changed), 32'h1);
    cyc(1);
    check("step_once", 32'(sw_changed), 32'h0);
    check("step_clean", 32'(sw_clean), 32'h1);

    // 3: bounce on bit 5 rejected
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      sw_raw[5] = (i % 2 == 0);
      quiet(3, h);
      acc += h;
    end
    sw_raw[5] = 1'b0;
    quiet(25, h);
    acc += h;
    check("bounce_pulses", 32'(acc), 32'h0);
    check("bounce_clean", 32'(sw_clean), 32'h1);

    // 4: late glitch on bit 7 restarts qualification
    sw_raw = '0;
    do_reset();
    sw_raw[7] = 1'b1;
    quiet(9, h);
    sw_raw[7] = 1'b0;
    quiet(1, h2);
    check("glitch_quiet", 32'(h + h2), 32'h0);
    sw_raw[7] = 1'b1;
    wait_pulse(30, n);
    check("glitch_lat", 32'(n >= 11 && n <= 14), 32'h1);
    check("glitch_pulse", 32'(sw_changed), 32'h80);
    check("glitch_clean", 32'(sw_clean), 32'h80);

    // 5: simultaneous transitions
    sw_raw = '0;
    do_reset();
    cyc(2);
    sw_raw = 18'h2AAAA;
    wait_pulse(30, n);
    check("multi_lat", 32'(n >= 11 && n <= 14), 32'h1);
    check("multi_pulse", 32'(sw_changed), 32'h2AAAA);
    check("multi_clean", 32'(sw_clean), 32'h2AAAA);
    cyc(1);
    check("multi_once", 32'(sw_changed), 32'h0);

    // 6: reset mid-qualification of bit 3
    sw_raw = '0;
    do_reset();
    cyc(1);
    sw_raw = 18'h8;
    quiet(8, h);
    check("mid_quiet", 32'(h), 32'h0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_chg", 32'(sw_changed), 32'h0);
    check("mid_rst_tick", 32'(tick), 32'h0);
    cyc(1);
    check("mid_rst_chg2", 32'(sw_changed), 32'h0);
    check("mid_rst_clean", 32'(sw_clean), 32'h0);
    reset_n = 1'b1;
    wait_pulse(30, n);
    check("mid_lat", 32'(n >= 11 && n <= 14), 32'h1);
    check("mid_pulse", 32'(sw_changed), 32'h8);
    cyc(1);
    check("mid_once", 32'(sw_changed), 32'h0);
    check("mid_clean", 32'(sw_clean), 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
